perf_counter_sampler: RTL and testbench

Periodic telemetry sampler sitting directly downstream of the performance counter bank, on its SRAM-like access port (5-bit address, write enable, 64-bit write data, 64-bit read data). On a timer or software trigger it sweeps the counter addresses FIRST_ADDR..LAST_ADDR, optionally clears each counter after reading it, and streams {addr, value, sweep sequence} records out through a small FIFO with a valid/ready handshake. The CSR file shares the same counter port through this block and always has priority.

---
 rtl/perf_counter_sampler.sv | 192 +++++++++++++++++++
 tb/tb_perf_counter_sampler.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_sampler.sv
// perf_counter_sampler
//   Periodic telemetry sampler placed in front of the performance counter
//   bank. A timer tick or a software trigger starts a sweep over
//   FIRST_ADDR..LAST_ADDR. Each counter read (optionally followed by a clear)
//   becomes a {addr, value, seq, last} record in a small output FIFO. The CSR
//   path shares the counter port and always wins it.
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   enable_i, period_i            periodic timer control (period 0 = off)
//   trigger_i                     software sweep request (pulse)
//   clear_on_read_i               zero each counter as it is sampled
//   csr_req_i/addr/we/wdata       CSR access to the bank
//   csr_rdata_o, csr_gnt_o        CSR read data, grant
//   pc_addr_o/we_o/wdata_o        counter bank port
//   pc_rdata_i                    bank read data (combinational on pc_addr_o)
//   sample_valid_o/ready_i        record stream handshake
//   sample_addr/data/seq/last_o   head record of the FIFO
//   busy_o                        sweep in progress
//   overrun_o, overrun_clr_i      sticky trigger-while-busy flag and its clear
module perf_counter_sampler #(
   parameter logic [4:0]  FIRST_ADDR = 5'd3,
   parameter logic [4:0]  LAST_ADDR  = 5'd18,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned PERIOD_W   = 16
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                enable_i,
   input  logic [PERIOD_W-1:0] period_i,
   input  logic                trigger_i,
   input  logic                clear_on_read_i,
   input  logic                csr_req_i,
   input  logic [4:0]          csr_addr_i,
   input  logic                csr_we_i,
   input  logic [63:0]         csr_wdata_i,
   output logic [63:0]         csr_rdata_o,
   output logic                csr_gnt_o,
   output logic [4:0]          pc_addr_o,
   output logic                pc_we_o,
   output logic [63:0]         pc_wdata_o,
   input  logic [63:0]         pc_rdata_i,
   output logic                sample_valid_o,
   input  logic                sample_ready_i,
   output logic [4:0]          sample_addr_o,
   output logic [63:0]         sample_data_o,
   output logic [15:0]         sample_seq_o,
   output logic                sample_last_o,
   output logic                busy_o,
   output logic                overrun_o,
   input  logic                overrun_clr_i
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [4:0]  addr;
      logic [63:0] data;
      logic [15:0] seq;
      logic        last;
   } rec_t;

   typedef enum logic {S_IDLE, S_SWEEP} state_t;

   state_t              r_state, w_state_nxt;
   logic [PERIOD_W-1:0] r_timer;
   logic [4:0]          r_cur_addr, w_cur_addr_nxt;
   logic [15:0]         r_seq, w_seq_nxt;
   logic                r_overrun;
   rec_t                r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
   logic [CNT_W-1:0]    r_count;

   logic w_tmr_run, w_tmr_hit, w_trig, w_full, w_step, w_pop, w_last;
   rec_t w_head;

   assign w_tmr_run = enable_i && (period_i != '0);
   assign w_tmr_hit = w_tmr_run && (r_timer == period_i - PERIOD_W'(1));
   assign w_trig    = w_tmr_hit || trigger_i;
   assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
   // One counter is read (and pushed) per cycle unless the CSR owns the
   // port or there is no room for the record.
   assign w_step    = (r_state == S_SWEEP) && !csr_req_i && !w_full;
   assign w_pop     = (r_count != '0) && sample_ready_i;
   assign w_last    = (r_cur_addr == LAST_ADDR);

   // Timer
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                    r_timer <= '0;
      else if (!w_tmr_run || w_tmr_hit) r_timer <= '0;
      else                            r_timer <= r_timer + PERIOD_W'(1);
   end

   // FSM
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= S_IDLE;
         r_cur_addr <= FIRST_ADDR;
         r_seq      <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_cur_addr <= w_cur_addr_nxt;
         r_seq      <= w_seq_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_cur_addr_nxt = r_cur_addr;
      w_seq_nxt      = r_seq;
      case (r_state)
         S_IDLE: begin
            if (w_trig) begin
               w_state_nxt    = S_SWEEP;
               w_cur_addr_nxt = FIRST_ADDR;
            end
         end
         S_SWEEP: begin
            if (w_step) begin
               if (w_last) begin
                  w_state_nxt    = S_IDLE;
                  w_cur_addr_nxt = FIRST_ADDR;
                  w_seq_nxt      = r_seq + 16'd1;
               end else begin
                  w_cur_addr_nxt = r_cur_addr + 5'd1;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Counter port mux: CSR has absolute priority.
   always_comb begin
      pc_addr_o  = '0;
      pc_we_o    = 1'b0;
      pc_wdata_o = '0;
      csr_gnt_o  = 1'b0;
      if (csr_req_i) begin
         pc_addr_o  = csr_addr_i;
         pc_we_o    = csr_we_i;
         pc_wdata_o = csr_wdata_i;
         csr_gnt_o  = 1'b1;
      end else if (w_step) begin
         // Clearing writes 0 in the read cycle; the bank returns the old value.
         pc_addr_o = r_cur_addr;
         pc_we_o   = clear_on_read_i;
      end
   end

   assign csr_rdata_o = pc_rdata_i;

   // Overrun: a trigger while sweeping is dropped; set beats clear.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                              r_overrun <= 1'b0;
      else if (w_trig && (r_state == S_SWEEP))  r_overrun <= 1'b1;
      else if (overrun_clr_i)                   r_overrun <= 1'b0;
   end

   // Output FIFO
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_step) begin
            r_mem[r_wr_ptr] <= '{addr: r_cur_addr, data: pc_rdata_i,
                                 seq: r_seq, last: w_last};
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_step, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign w_head         = r_mem[r_rd_ptr];
   assign sample_valid_o = (r_count != '0);
   assign sample_addr_o  = w_head.addr;
   assign sample_data_o  = w_head.data;
   assign sample_seq_o   = w_head.seq;
   assign sample_last_o  = w_head.last;
   assign busy_o         = (r_state == S_SWEEP);
   assign overrun_o      = r_overrun;

endmodule

// File: tb/tb_perf_counter_sampler.sv
module tb_perf_counter_sampler;

   localparam int FIRST = 3;
   localparam int LAST  = 18;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        enable_i = 1'b0;
   logic [15:0] period_i = '0;
   logic        trigger_i = 1'b0;
   logic        clear_on_read_i = 1'b0;
   logic        csr_req_i = 1'b0;
   logic [4:0]  csr_addr_i = '0;
   logic        csr_we_i = 1'b0;
   logic [63:0] csr_wdata_i = '0;
   logic [63:0] csr_rdata_o;
   logic        csr_gnt_o;
   logic [4:0]  pc_addr_o;
   logic        pc_we_o;
   logic [63:0] pc_wdata_o;
   logic [63:0] pc_rdata_i;
   logic        sample_valid_o;
   logic        sample_ready_i = 1'b0;
   logic [4:0]  sample_addr_o;
   logic [63:0] sample_data_o;
   logic [15:0] sample_seq_o;
   logic        sample_last_o;
   logic        busy_o;
   logic        overrun_o;
   logic        overrun_clr_i = 1'b0;

   perf_counter_sampler #(.FIRST_ADDR(5'd3), .LAST_ADDR(5'd18), .FIFO_DEPTH(4), .PERIOD_W(16)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .period_i(period_i),
      .trigger_i(trigger_i), .clear_on_read_i(clear_on_read_i),
      .csr_req_i(csr_req_i), .csr_addr_i(csr_addr_i), .csr_we_i(csr_we_i),
      .csr_wdata_i(csr_wdata_i), .csr_rdata_o(csr_rdata_o), .csr_gnt_o(csr_gnt_o),
      .pc_addr_o(pc_addr_o), .pc_we_o(pc_we_o), .pc_wdata_o(pc_wdata_o),
      .pc_rdata_i(pc_rdata_i), .sample_valid_o(sample_valid_o),
      .sample_ready_i(sample_ready_i), .sample_addr_o(sample_addr_o),
      .sample_data_o(sample_data_o), .sample_seq_o(sample_seq_o),
      .sample_last_o(sample_last_o), .busy_o(busy_o), .overrun_o(overrun_o),
      .overrun_clr_i(overrun_clr_i)
   );

   always #5 clk_i = ~clk_i;

   // Counter bank: combinational read, synchronous write.
   logic [63:0] bank [32];
   always @(posedge clk_i) if (pc_we_o) bank[pc_addr_o] <= pc_wdata_o;
   assign pc_rdata_i = bank[pc_addr_o];

   typedef struct {
      logic [4:0]  addr;
      logic [63:0] data;
      logic [15:0] seq;
      logic        last;
   } rec_t;

   typedef struct {
      logic        req;
      logic [4:0]  addr;
      logic        we;
      logic [63:0] wdata;
      logic [4:0]  e_addr;
      logic        e_we;
      logic        e_gnt;
   } vec_t;

   rec_t        got_q[$];
   rec_t        exp_q[$];
   int          start_q[$];
   logic [63:0] shadow [32];
   logic [15:0] seq_m = '0;
   int checks = 0, failures = 0;
   int busy_cnt = 0, acc_cnt = 0, cyc = 0;
   logic busy_prev = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: a sweep reads every counter in range once, in order, from the
   // model's view of the bank; clearing zeroes it afterwards.
   task automatic model_sweep(input bit clr);
      rec_t r;
      for (int a = FIRST; a <= LAST; a++) begin
         r.addr = 5'(a); r.data = shadow[a]; r.seq = seq_m; r.last = (a == LAST);
         exp_q.push_back(r);
         if (clr) shadow[a] = '0;
      end
      seq_m = seq_m + 16'd1;
   endtask

   task automatic cmp_recs(input string name);
      chk({name, " count"}, 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i].addr !== exp_q[i].addr || got_q[i].data !== exp_q[i].data ||
             got_q[i].seq !== exp_q[i].seq || got_q[i].last !== exp_q[i].last) begin
            failures++;
            $display("FAIL %s rec%0d: got a=%0d d=%0h s=%0d l=%0b expected a=%0d d=%0h s=%0d l=%0b",
                     name, i, got_q[i].addr, got_q[i].data, got_q[i].seq, got_q[i].last,
                     exp_q[i].addr, exp_q[i].data, exp_q[i].seq, exp_q[i].last);
         end
      end
      got_q.delete();
      exp_q.delete();
   endtask

   // One clock: observe just after the negedge drive, then advance to next negedge.
   task automatic tick();
      rec_t r;
      #1;
      if (sample_valid_o && sample_ready_i) begin
         r.addr = sample_addr_o; r.data = sample_data_o;
         r.seq = sample_seq_o; r.last = sample_last_o;
         got_q.push_back(r);
      end
      if (busy_o) busy_cnt++;
      if (busy_o && !busy_prev) start_q.push_back(cyc);
      busy_prev = busy_o;
      if (!csr_req_i && busy_o && pc_addr_o != 5'd0) acc_cnt++;
      if (csr_req_i)
         chk("csr_mux", {pc_addr_o, pc_we_o, pc_wdata_o == csr_wdata_i, csr_gnt_o},
             {csr_addr_i, csr_we_i, 1'b1, 1'b1});
      else if (!busy_o)
         chk("idle_port", {pc_addr_o, pc_we_o, csr_gnt_o}, '0);
      cyc++;
      @(negedge clk_i);
      trigger_i = 1'b0;
      overrun_clr_i = 1'b0;
   endtask

   task automatic drain(input string name, input int budget);
      int n = 0;
      sample_ready_i = 1'b1;
      while ((busy_o || sample_valid_o) && n < budget) begin
         tick();
         n++;
      end
      chk({name, " drain_timeout"}, 64'(n < budget), 64'd1);
   endtask

   task automatic csr_wr(input logic [4:0] a, input logic [63:0] d);
      csr_req_i = 1'b1; csr_addr_i = a; csr_we_i = 1'b1; csr_wdata_i = d;
      tick();
      csr_req_i = 1'b0; csr_we_i = 1'b0;
      shadow[a] = d;
   endtask

   task automatic csr_rd(input string name, input logic [4:0] a);
      csr_req_i = 1'b1; csr_addr_i = a; csr_we_i = 1'b0;
      #1 chk(name, csr_rdata_o, shadow[a]);
      tick();
      csr_req_i = 1'b0;
   endtask

   task automatic pulse_trigger();
      trigger_i = 1'b1;
      tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt[6];
      int n;
      bit clr;

      vt[0] = '{1'b0, 5'd9,  1'b1, 64'h1234,      5'd0,  1'b0, 1'b0};
      vt[1] = '{1'b1, 5'd9,  1'b0, 64'h0,         5'd9,  1'b0, 1'b1};
      vt[2] = '{1'b1, 5'd21, 1'b1, 64'hDEADBEEF,  5'd21, 1'b1, 1'b1};
      vt[3] = '{1'b1, 5'd21, 1'b0, 64'h0,         5'd21, 1'b0, 1'b1};
      vt[4] = '{1'b0, 5'd21, 1'b0, 64'h0,         5'd0,  1'b0, 1'b0};
      vt[5] = '{1'b1, 5'd31, 1'b1, 64'h5,         5'd31, 1'b1, 1'b1};

      // Reset state
      repeat (3) @(negedge clk_i);
      chk("rst_sample", {sample_valid_o, sample_addr_o, sample_seq_o, sample_last_o}, '0);
      chk("rst_data", sample_data_o, '0);
      chk("rst_status", {busy_o, overrun_o, pc_we_o, pc_addr_o, csr_gnt_o}, '0);
      rst_ni = 1'b1;
      @(negedge clk_i);

      for (int a = 0; a < 32; a++) csr_wr(5'(a), 64'(a * 16));

      // Port mux vectors while idle
      for (int i = 0; i < 6; i++) begin
         csr_req_i = vt[i].req; csr_addr_i = vt[i].addr;
         csr_we_i = vt[i].we; csr_wdata_i = vt[i].wdata;
         #1;
         chk($sformatf("vec%0d port", i), {pc_addr_o, pc_we_o, csr_gnt_o},
             {vt[i].e_addr, vt[i].e_we, vt[i].e_gnt});
         if (vt[i].req) chk($sformatf("vec%0d rdata", i), csr_rdata_o, shadow[vt[i].addr]);
         if (vt[i].req && vt[i].we) chk($sformatf("vec%0d wdata", i), pc_wdata_o, vt[i].wdata);
         tick();
         if (vt[i].req && vt[i].we) shadow[vt[i].addr] = vt[i].wdata;
      end
      csr_req_i = 1'b0; csr_we_i = 1'b0;

      // Basic software-triggered sweep
      sample_ready_i = 1'b1;
      busy_cnt = 0;
      model_sweep(1'b0);
      pulse_trigger();
      chk("sweep1 busy_start", 64'(busy_o), 64'd1);
      drain("sweep1", 100);
      chk("sweep1 busy_cycles", 64'(busy_cnt), 64'd16);
      cmp_recs("sweep1");

      // Periodic timer
      start_q.delete(); cyc = 0;
      enable_i = 1'b1; period_i = 16'd40;
      repeat (140) tick();
      enable_i = 1'b0;
      drain("timer", 100);
      chk("timer sweeps", 64'(start_q.size()), 64'd3);
      if (start_q.size() == 3) begin
         chk("timer first", 64'(start_q[0]), 64'd40);
         chk("timer gap1", 64'(start_q[1] - start_q[0]), 64'd40);
         chk("timer gap2", 64'(start_q[2] - start_q[1]), 64'd40);
      end
      repeat (3) model_sweep(1'b0);
      cmp_recs("timer");
      period_i = 16'd0; enable_i = 1'b1; busy_cnt = 0;
      repeat (100) tick();
      chk("period0 busy", 64'(busy_cnt), 64'd0);
      chk("period0 recs", 64'(got_q.size()), 64'd0);
      enable_i = 1'b0;

      // Backpressure: FIFO fills, sweep stalls without touching the bank
      sample_ready_i = 1'b0; acc_cnt = 0;
      model_sweep(1'b0);
      pulse_trigger();
      repeat (30) tick();
      chk("bp accesses", 64'(acc_cnt), 64'd4);
      chk("bp busy", 64'(busy_o), 64'd1);
      chk("bp head", {sample_valid_o, sample_addr_o}, {1'b1, 5'd3});
      chk("bp popped", 64'(got_q.size()), 64'd0);
      drain("bp", 100);
      cmp_recs("bp");

      // CSR steals the port mid-sweep
      sample_ready_i = 1'b1;
      pulse_trigger();
      n = 0;
      while (pc_addr_o !== 5'd7 && n < 30) begin tick(); n++; end
      chk("csr reach7", 64'(n < 30), 64'd1);
      csr_req_i = 1'b1; csr_addr_i = 5'd10; csr_we_i = 1'b1; csr_wdata_i = 64'hABCD;
      #1 chk("csr wr port", {csr_gnt_o, pc_addr_o, pc_we_o}, {1'b1, 5'd10, 1'b1});
      tick();
      shadow[10] = 64'hABCD;
      csr_we_i = 1'b0;
      #1 chk("csr rd10", csr_rdata_o, 64'hABCD);
      tick();
      csr_addr_i = 5'd12;
      #1 chk("csr rd12", csr_rdata_o, shadow[12]);
      tick();
      csr_req_i = 1'b0;
      #1 chk("csr resume7", {pc_addr_o, csr_gnt_o}, {5'd7, 1'b0});
      model_sweep(1'b0);
      drain("csr", 100);
      cmp_recs("csr");

      // Clear on read
      csr_wr(5'd5, 64'h99);
      clear_on_read_i = 1'b1;
      model_sweep(1'b1);
      pulse_trigger();
      drain("clr", 100);
      clear_on_read_i = 1'b0;
      cmp_recs("clr");
      csr_rd("clr rd5", 5'd5);
      csr_rd("clr rd18", 5'd18);

      // Overrun
      model_sweep(1'b0);
      pulse_trigger();
      repeat (3) tick();
      trigger_i = 1'b1;
      tick();
      chk("ovr set", 64'(overrun_o), 64'd1);
      drain("ovr", 100);
      cmp_recs("ovr");
      chk("ovr sticky", 64'(overrun_o), 64'd1);
      overrun_clr_i = 1'b1;
      tick();
      chk("ovr clear", 64'(overrun_o), 64'd0);
      model_sweep(1'b0);
      pulse_trigger();
      tick();
      trigger_i = 1'b1;
      tick();
      chk("ovr set2", 64'(overrun_o), 64'd1);
      trigger_i = 1'b1; overrun_clr_i = 1'b1;
      tick();
      chk("ovr set_wins", 64'(overrun_o), 64'd1);
      overrun_clr_i = 1'b1;
      tick();
      chk("ovr clear2", 64'(overrun_o), 64'd0);
      drain("ovr2", 100);
      cmp_recs("ovr2");

      // Reset mid-sweep discards everything
      sample_ready_i = 1'b0;
      pulse_trigger();
      repeat (5) tick();
      rst_ni = 1'b0;
      #1;
      chk("midrst out", {sample_valid_o, busy_o, overrun_o, sample_seq_o}, '0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      seq_m = '0;
      got_q.delete();
      model_sweep(1'b0);
      pulse_trigger();
      drain("midrst", 100);
      cmp_recs("midrst");

      // Randomized sweeps with random backpressure, CSR reads and clearing
      for (int it = 0; it < 6; it++) begin
         for (int a = FIRST; a <= LAST; a++)
            if ($urandom_range(0, 1) == 1) csr_wr(5'(a), {$urandom, $urandom});
         clr = 1'($urandom_range(0, 1));
         clear_on_read_i = clr;
         model_sweep(clr);
         pulse_trigger();
         n = 0;
         while ((busy_o || sample_valid_o) && n < 500) begin
            sample_ready_i = ($urandom_range(0, 2) != 0);
            csr_req_i = ($urandom_range(0, 3) == 0);
            csr_addr_i = 5'($urandom_range(0, 31));
            csr_we_i = 1'b0;
            tick();
            n++;
         end
         csr_req_i = 1'b0; sample_ready_i = 1'b1; clear_on_read_i = 1'b0;
         chk($sformatf("rand%0d timeout", it), 64'(n < 500), 64'd1);
         cmp_recs($sformatf("rand%0d", it));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
